// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit producing the {hi, lo} result for the HI/LO register.
// Multiplies take one cycle; divides run 32 restoring radix-2 iterations on magnitudes.
module hilo_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [63:0] hilo_o
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [31:0] a_l, b_l;
    logic [1:0]  op_l;
    logic [5:0]  cnt;
    logic [31:0] quo, rem, b_mag;

    logic        a_neg_in, b_neg_in;
    logic [31:0] a_mag_in, b_mag_in;
    logic        sa, sb;
    logic [63:0] mul_full;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] diff, rem_nx, quo_nx;
    logic        q_neg, r_neg;
    logic [31:0] q_fix, r_fix;
    logic [63:0] div_res;

    always_comb begin
        a_neg_in = ~op[0] & a[31];
        b_neg_in = ~op[0] & b[31];
        a_mag_in = a_neg_in ? (~a + 32'd1) : a;
        b_mag_in = b_neg_in ? (~b + 32'd1) : b;

        // Sign-extend only for MULT; the low 64 bits of the wide product are the result.
        sa       = ~op_l[0] & a_l[31];
        sb       = ~op_l[0] & b_l[31];
        mul_full = {{32{sa}}, a_l} * {{32{sb}}, b_l};

        shifted  = {rem, quo[31]};
        fits     = shifted >= {1'b0, b_mag};
        diff     = shifted[31:0] - b_mag;
        rem_nx   = fits ? diff : shifted[31:0];
        quo_nx   = {quo[30:0], fits};

        q_neg    = ~op_l[0] & (a_l[31] ^ b_l[31]);
        r_neg    = ~op_l[0] & a_l[31];
        q_fix    = q_neg ? (~quo_nx + 32'd1) : quo_nx;
        r_fix    = r_neg ? (~rem_nx + 32'd1) : rem_nx;
        div_res  = (b_l == '0) ? {a_l, 32'hFFFF_FFFF} : {r_fix, q_fix};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_l    <= '0;
            b_l    <= '0;
            op_l   <= '0;
            cnt    <= '0;
            quo    <= '0;
            rem    <= '0;
            b_mag  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hilo_o <= '0;
        end else if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_l   <= a;
                        b_l   <= b;
                        op_l  <= op;
                        quo   <= a_mag_in;
                        rem   <= '0;
                        b_mag <= b_mag_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= op[1] ? DIV : MUL;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                MUL: begin
                    hilo_o <= mul_full;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DIV: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + 6'd1;
                    // Final iteration writes the sign-corrected result directly.
                    if (cnt == 6'd31) begin
                        hilo_o <= div_res;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: vector table with a result scoreboard,
// plus hand-written cancel, ignored-start, back-to-back and async-reset sequences.
module tb_hilo_muldiv;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        cancel;
    logic        busy, done;
    logic [63:0] hilo_o;

    hilo_muldiv dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hilo_o(hilo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        int          busy_cyc;
    } vec_t;

    vec_t        vecs[13];
    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int cyc = 0;
        int bc  = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " busy cycles"}, 64'(bc), 64'(exp_busy));
        check({name, " latency"}, 64'(cyc), 64'(exp_busy));
        if (exp_q.size() == 0) check({name, " scoreboard empty"}, 64'd0, 64'd1);
        else check({name, " hilo"}, hilo_o, exp_q.pop_front());
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        check({name, " done pulse width"}, 64'(done), 64'd0);
        check({name, " idle busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] prior;
        int          pulses;

        vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,          64'hFFFF_FFFF_FFFF_FFF1, 1};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 1};
        vecs[2]  = '{2'b11, 32'd100,       32'd7,          64'h0000_0002_0000_000E, 32};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD, 32};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000, 32};
        vecs[5]  = '{2'b10, 32'd5,         32'd0,          64'h0000_0005_FFFF_FFFF, 32};
        vecs[6]  = '{2'b11, 32'h8000_0000, 32'd0,          64'h8000_0000_FFFF_FFFF, 32};
        vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD, 32};
        vecs[8]  = '{2'b00, 32'h8000_0000, 32'h8000_0000,  64'h4000_0000_0000_0000, 1};
        vecs[9]  = '{2'b01, 32'h8000_0000, 32'd2,          64'h0000_0001_0000_0000, 1};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'd1,          64'h0000_0000_FFFF_FFFF, 32};
        vecs[11] = '{2'b10, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  64'hFFFF_FFFE_0000_000E, 32};
        vecs[12] = '{2'b11, 32'd1,         32'hFFFF_FFFF,  64'h0000_0001_0000_0000, 32};

        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; cancel = 1'b0;
        #3;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset hilo", hilo_o, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            exp_q.push_back(vecs[i].hilo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), vecs[i].busy_cyc);
            idle_check($sformatf("vec%0d", i));
        end

        // Cancel at iteration 10 of a divide: no done, result held.
        prior = hilo_o;
        issue(2'b11, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        start  = 1'b1;
        op     = 2'b00;
        @(negedge clk);
        cancel = 1'b0;
        start  = 1'b0;
        check("cancel busy", 64'(busy), 64'd0);
        check("cancel done", 64'(done), 64'd0);
        check("cancel hilo held", hilo_o, prior);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        check("cancel no activity", 64'(pulses), 64'd0);
        check("cancel hilo still held", hilo_o, prior);
        exp_q.push_back(64'h0000_0000_0000_000C);
        issue(2'b00, 32'd3, 32'd4);
        wait_done("post-cancel mult", 1);
        idle_check("post-cancel mult");

        // Start during busy must be ignored.
        exp_q.push_back(64'h0000_0002_0000_000E);
        issue(2'b11, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done("start ignored", 26);
        idle_check("start ignored");

        // Back-to-back start in DONE.
        exp_q.push_back(64'h0000_0000_0000_002A);
        issue(2'b00, 32'd6, 32'd7);
        wait_done("b2b first", 1);
        exp_q.push_back(64'h0000_0001_0000_0002);
        issue(2'b11, 32'd5, 32'd2);
        wait_done("b2b second", 32);
        idle_check("b2b second");

        // Asynchronous reset mid-divide.
        exp_q.push_back(64'h0000_0000_0000_0001);
        issue(2'b11, 32'd7, 32'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst done", 64'(done), 64'd0);
        check("async rst hilo", hilo_o, 64'd0);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("after rst busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
